memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Word-addressed memory slave with a fixed busy window per access.
// Each accepted access completes LATENCY cycles later; requests are ignored until then.
module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        busy,
    output logic        addr_error
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          op_wr;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    wbe;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          req_ok;
    logic          enter_done;
    logic          rd_op;
    logic          rd_ok;
    logic [AW-1:0] rd_idx;
    logic          commit;
    logic          unused;

    assign unused = ^addr[1:0];
    assign req    = ren | wen;
    assign req_ok = (addr[31:AW+2] == '0);

    assign busy = !reset &&
                  ((state == WAIT) || (state == IDLE && req));

    // With LATENCY=1 the read is resolved straight from the live request.
    assign enter_done = (state == WAIT && cnt == 4'd1) ||
                        (LATENCY == 1 && state == IDLE && req);
    assign rd_op  = (state == IDLE) ? !wen : !op_wr;
    assign rd_ok  = (state == IDLE) ? req_ok : in_range;
    assign rd_idx = (state == IDLE) ? addr[AW+1:2] : idx;

    assign commit = !reset && state == DONE && op_wr && in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dout       <= '0;
            addr_error <= 1'b0;
        end else begin
            addr_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_wr    <= wen;
                        in_range <= req_ok;
                        idx      <= addr[AW+1:2];
                        wdata    <= din;
                        wbe      <= be;
                        cnt      <= CNT_INIT;
                        state    <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_done) begin
                addr_error <= !rd_ok;
                if (rd_op)
                    dout <= rd_ok ? mem[rd_idx] : 32'h0;
            end
        end
    end

    // Storage has no reset; only the DONE cycle of an in-range write commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++)
                if (wbe[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule
